// File: rtl/mult_arbiter_pkg.sv
// mult_arbiter_pkg: state encoding and datapath widths shared by the multiplier arbiter
package mult_arbiter_pkg;
    localparam int OPW = 8;
    localparam int RESW = 16;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        WAIT    = 3'd2,
        RESPOND = 3'd3,
        RELEASE = 3'd4
    } state_t;
endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first set request after ptr wins
module rr_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic            found,
    output logic [2:0]      idx
);
    int d;
    int best;
    always_comb begin
        found = 1'b0;
        idx = 3'd0;
        d = 0;
        best = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            // distance from ptr+1 going upwards, wrapping modulo NREQ
            d = (i + 2 * NREQ - int'(ptr) - 1) % NREQ;
            if (req[i] && d < best) begin
                best = d;
                found = 1'b1;
                idx = 3'(i);
            end
        end
    end
endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one 8x8 multiplier between NREQ requesters, with watchdog
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_ld,
    input  logic [OPW*NREQ-1:0] req_a,
    input  logic [OPW*NREQ-1:0] req_b,
    output logic [NREQ-1:0]     req_ok,
    output logic [RESW-1:0]     req_res,
    output logic [OPW-1:0]      mult1,
    output logic [OPW-1:0]      mult2,
    output logic                ld,
    input  logic                mult_ok,
    input  logic [RESW-1:0]     mult_res,
    output logic                busy,
    output logic [2:0]          grant_idx,
    output logic                timeout_err
);
    state_t state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [2:0] grant_n, win;
    logic [OPW-1:0] mult1_n, mult2_n;
    logic [NREQ-1:0] ok_n;
    logic [RESW-1:0] res_n;
    logic ld_n, err_n, found;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req(req_ld),
        .ptr(grant_idx),
        .found(found),
        .idx(win)
    );

    always_comb begin
        state_n = state;
        grant_n = grant_idx;
        mult1_n = mult1;
        mult2_n = mult2;
        ld_n = ld;
        ok_n = req_ok;
        res_n = req_res;
        err_n = timeout_err;
        cnt_n = cnt;
        case (state)
            IDLE: if (found) begin
                grant_n = win;
                for (int i = 0; i < NREQ; i++)
                    if (win == 3'(i)) begin
                        mult1_n = req_a[OPW*i +: OPW];
                        mult2_n = req_b[OPW*i +: OPW];
                    end
                state_n = ARM;
            end
            ARM: if (!mult_ok) begin
                ld_n = 1'b1;
                cnt_n = 8'd0;
                state_n = WAIT;
            end
            WAIT: begin
                cnt_n = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                // an abort still completes the handshake, with a zero result
                if (mult_ok || cnt >= 8'(TIMEOUT - 1)) begin
                    ld_n = 1'b0;
                    ok_n = NREQ'(1) << grant_idx;
                    res_n = mult_ok ? mult_res : '0;
                    err_n = timeout_err | !mult_ok;
                    state_n = RESPOND;
                end
            end
            RESPOND: if (!(|(req_ld & req_ok))) begin
                ok_n = '0;
                state_n = RELEASE;
            end
            RELEASE: if (!mult_ok) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            grant_idx <= 3'(NREQ - 1);
            mult1 <= '0;
            mult2 <= '0;
            ld <= 1'b0;
            req_ok <= '0;
            req_res <= '0;
            timeout_err <= 1'b0;
            cnt <= 8'd0;
            busy <= 1'b0;
        end else begin
            state <= state_n;
            grant_idx <= grant_n;
            mult1 <= mult1_n;
            mult2 <= mult2_n;
            ld <= ld_n;
            req_ok <= ok_n;
            req_res <= res_n;
            timeout_err <= err_n;
            cnt <= cnt_n;
            busy <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed scenarios plus random traffic checked against a transaction-level model
module tb_mult_arbiter;
    localparam int NREQ = 3;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NREQ-1:0] req_ld = '0;
    logic [8*NREQ-1:0] req_a = '0;
    logic [8*NREQ-1:0] req_b = '0;
    logic [NREQ-1:0] req_ok;
    logic [15:0] req_res;
    logic [7:0] mult1, mult2;
    logic ld;
    logic mult_ok = 1'b0;
    logic [15:0] mult_res = '0;
    logic busy;
    logic [2:0] grant_idx;
    logic timeout_err;

    int tests = 0;
    int errors = 0;

    int lat = 1;
    int mcnt = 0;
    logic mok_force = 1'b0;
    logic mok_dead = 1'b0;

    mult_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .reset(reset),
        .req_ld(req_ld),
        .req_a(req_a),
        .req_b(req_b),
        .req_ok(req_ok),
        .req_res(req_res),
        .mult1(mult1),
        .mult2(mult2),
        .ld(ld),
        .mult_ok(mult_ok),
        .mult_res(mult_res),
        .busy(busy),
        .grant_idx(grant_idx),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // multiplier: mult_ok rises lat edges after ld is first seen, follows ld down
    always @(posedge clk) begin
        mcnt <= ld ? mcnt + 1 : 0;
        mult_ok <= mok_force || (ld && !mok_dead && mcnt + 1 >= lat);
        mult_res <= 16'(mult1) * 16'(mult2);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 1; k <= NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return 0;
    endfunction

    // transaction-level model: ph 0 idle, 1 arm, 2 wait, 3 respond, 4 release
    logic p_rst = 1'b1;
    logic [NREQ-1:0] p_req = '0;
    logic [8*NREQ-1:0] p_a = '0;
    logic [8*NREQ-1:0] p_b = '0;
    logic p_mok = 1'b0;
    int ph = 0;
    int ptr = NREQ - 1;
    int g = 0;
    int n = 0;
    logic [7:0] ga = '0;
    logic [7:0] gb = '0;
    logic [15:0] r_m = '0;
    logic err_m = 1'b0;

    always @(negedge clk) begin
        if (p_rst) begin
            check("rst_busy", busy, 0);
            check("rst_ld", ld, 0);
            check("rst_ok", req_ok, 0);
            check("rst_res", req_res, 0);
            check("rst_mult1", mult1, 0);
            check("rst_grant", grant_idx, NREQ - 1);
            check("rst_err", timeout_err, 0);
            ph = 0;
            ptr = NREQ - 1;
            err_m = 1'b0;
        end else begin
            case (ph)
                0: if (|p_req) begin
                    g = pick(p_req, ptr);
                    ptr = g;
                    ga = p_a[8*g +: 8];
                    gb = p_b[8*g +: 8];
                    check("grant_idx", grant_idx, g);
                    check("grant_busy", busy, 1);
                    check("grant_mult1", mult1, ga);
                    check("grant_mult2", mult2, gb);
                    check("grant_ld", ld, 0);
                    ph = 1;
                end else begin
                    check("idle_busy", busy, 0);
                    check("idle_grant", grant_idx, ptr);
                    check("idle_ld", ld, 0);
                end
                1: begin
                    check("arm_ld", ld, !p_mok);
                    check("arm_ok", req_ok, 0);
                    check("arm_mult1", mult1, ga);
                    if (!p_mok) begin
                        ph = 2;
                        n = 1;
                    end
                end
                2: if (p_mok || n == TIMEOUT) begin
                    r_m = p_mok ? 16'(ga) * 16'(gb) : 16'h0000;
                    if (!p_mok) err_m = 1'b1;
                    check("done_ld", ld, 0);
                    check("done_ok", req_ok, 1 << g);
                    check("done_res", req_res, r_m);
                    ph = 3;
                end else begin
                    check("wait_ld", ld, 1);
                    check("wait_ok", req_ok, 0);
                    check("wait_mult1", mult1, ga);
                    check("wait_mult2", mult2, gb);
                    n++;
                end
                3: if (p_req[g]) begin
                    check("resp_ok", req_ok, 1 << g);
                    check("resp_res", req_res, r_m);
                end else begin
                    check("resp_clr", req_ok, 0);
                    ph = 4;
                end
                default: begin
                    check("rel_ok", req_ok, 0);
                    check("rel_busy", busy, p_mok);
                    if (!p_mok) ph = 0;
                end
            endcase
            check("err_flag", timeout_err, err_m);
            check("ok_onehot", $onehot0(req_ok), 1);
        end
        p_rst = reset;
        p_req = req_ld;
        p_a = req_a;
        p_b = req_b;
        p_mok = mult_ok;
    end

    initial begin
        int w;
        int cnt_ld;
        int e;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        check("init_grant", grant_idx, 2);
        check("init_busy", busy, 0);
        check("init_ld", ld, 0);

        // lone request, 1-cycle multiplier
        req_ld = 3'b001;
        req_a[7:0] = 8'h80;
        req_b[7:0] = 8'hFF;
        cyc();
        check("t1_busy", busy, 1);
        check("t1_ld_e0", ld, 0);
        check("t1_mult1", mult1, 8'h80);
        cyc();
        check("t1_ld_e1", ld, 1);
        cyc();
        check("t1_ok_e2", req_ok, 0);
        cyc();
        check("t1_ok_e3", req_ok, 3'b001);
        check("t1_res", req_res, 16'h7F80);
        repeat (3) begin
            cyc();
            check("t1_ok_hold", req_ok, 3'b001);
        end
        req_ld = '0;
        cyc();
        check("t1_ok_drop", req_ok, 0);
        w = 0;
        while (busy && w < 20) begin cyc(); w++; end
        check("t1_idle", busy, 0);

        // multiplier never answers: watchdog abort, then a late mult_ok is absorbed
        mok_dead = 1'b1;
        req_ld = 3'b010;
        req_a[15:8] = 8'h21;
        req_b[15:8] = 8'h43;
        w = 0;
        while (!ld && w < 20) begin cyc(); w++; end
        cnt_ld = 0;
        while (ld && cnt_ld < 20) begin cnt_ld++; cyc(); end
        check("to_ld_cycles", cnt_ld, TIMEOUT);
        check("to_err", timeout_err, 1);
        check("to_res", req_res, 0);
        check("to_ok", req_ok, 3'b010);
        mok_force = 1'b1;
        cyc();
        req_ld = '0;
        cyc();
        repeat (3) begin
            cyc();
            check("late_busy", busy, 1);
            check("late_ok", req_ok, 0);
        end
        mok_force = 1'b0;
        mok_dead = 1'b0;
        repeat (3) cyc();
        check("late_idle", busy, 0);
        check("late_ok_idle", req_ok, 0);

        // reset while in WAIT
        mok_dead = 1'b1;
        req_ld = 3'b001;
        w = 0;
        while (!ld && w < 20) begin cyc(); w++; end
        cyc();
        reset = 1'b1;
        req_ld = '0;
        cyc();
        check("rw_ld", ld, 0);
        check("rw_ok", req_ok, 0);
        check("rw_busy", busy, 0);
        check("rw_err", timeout_err, 0);
        check("rw_grant", grant_idx, 2);
        reset = 1'b0;
        mok_dead = 1'b0;

        // both requesters pending: strict alternation starting at 0
        req_a[7:0] = 8'd3;
        req_b[7:0] = 8'd5;
        req_a[15:8] = 8'd7;
        req_b[15:8] = 8'd9;
        req_ld = 3'b011;
        for (int t = 0; t < 4; t++) begin
            w = 0;
            while (req_ok == 0 && w < 40) begin cyc(); w++; end
            e = t % 2;
            check("alt_ok", req_ok, 1 << e);
            check("alt_grant", grant_idx, e);
            check("alt_res", req_res, e == 0 ? 16'h000F : 16'h003F);
            req_ld[e] = 1'b0;
            cyc();
            req_ld[e] = 1'b1;
        end
        req_ld = '0;
        repeat (8) cyc();

        // mult_ok stuck high from before reset release
        mok_force = 1'b1;
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        req_ld = 3'b100;
        req_a[23:16] = 8'h11;
        req_b[23:16] = 8'h02;
        cyc();
        check("arm_grant", grant_idx, 2);
        repeat (4) begin
            cyc();
            check("arm_hold_busy", busy, 1);
            check("arm_hold_ld", ld, 0);
        end
        mok_force = 1'b0;
        cyc();
        check("arm_ld_f0", ld, 0);
        cyc();
        check("arm_ld_f1", ld, 1);
        w = 0;
        while (req_ok == 0 && w < 20) begin cyc(); w++; end
        check("arm_res", req_res, 16'h0022);
        req_ld = '0;
        repeat (6) cyc();

        // operands changed after grant do not reach the multiplier
        lat = 3;
        req_ld = 3'b010;
        req_a[15:8] = 8'h12;
        req_b[15:8] = 8'h34;
        w = 0;
        while (!ld && w < 20) begin cyc(); w++; end
        req_a[15:8] = 8'hFF;
        cyc();
        check("opchg_mult1_a", mult1, 8'h12);
        cyc();
        check("opchg_mult1_b", mult1, 8'h12);
        w = 0;
        while (req_ok == 0 && w < 20) begin cyc(); w++; end
        check("opchg_res", req_res, 16'h03A8);
        req_ld = '0;
        repeat (6) cyc();

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            cyc();
            if (c % 16 == 0) lat = $urandom_range(1, 5);
            for (int i = 0; i < NREQ; i++) begin
                if (req_ld[i]) begin
                    if (req_ok[i] ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) == 0))
                        req_ld[i] = 1'b0;
                    else if ($urandom_range(0, 5) == 0)
                        req_a[8*i +: 8] = 8'($urandom);
                end else if (!req_ok[i] && $urandom_range(0, 2) == 0) begin
                    req_ld[i] = 1'b1;
                    req_a[8*i +: 8] = 8'($urandom);
                    req_b[8*i +: 8] = 8'($urandom);
                end
            end
            reset = ($urandom_range(0, 499) == 0);
        end
        reset = 1'b0;
        req_ld = '0;
        repeat (12) cyc();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
